// File: rtl/labka13_sweep_ctrl.sv
// Truth-table sweeper: steps a 4-bit stimulus through 0..15, waits SETTLE
// cycles per vector, then samples a 1-bit response into a 16-bit table.
module labka13_sweep_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        f_in_i,
  output logic [3:0]  x_out_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] tt_o,
  output logic [4:0]  ones_cnt_o
);

  localparam int unsigned CW = 4;
  localparam int unsigned XW = 4;
  localparam int unsigned TW = 16;
  localparam int unsigned OW = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [TW-1:0] tt_q, tt_d;
  logic [OW-1:0] ones_q, ones_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      wait_q  <= '0;
      tt_q    <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      wait_q  <= wait_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update; x_q doubles as the vector index
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    wait_d  = wait_q;
    tt_d    = tt_q;
    ones_d  = ones_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_SETTLE;
          x_d     = '0;
          wait_d  = '0;
          tt_d    = '0;
          ones_d  = '0;
        end
      end
      S_SETTLE: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (wait_q == CW'(SETTLE - 1)) begin
          state_d = S_SAMPLE;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      S_SAMPLE: begin
        // An abort in this cycle drops the pending sample
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          tt_d[x_q] = f_in_i;
          ones_d    = ones_q + OW'(f_in_i);
          if (x_q == XW'(15)) begin
            state_d = S_DONE;
          end else begin
            x_d     = x_q + XW'(1);
            wait_d  = '0;
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are registered copies of the upcoming state
  always_comb begin
    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

  assign x_out_o    = x_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign tt_o       = tt_q;
  assign ones_cnt_o = ones_q;

endmodule

// File: tb/tb_labka13_sweep_ctrl.sv
// Bench for labka13_sweep_ctrl: two instances (SETTLE=2 and SETTLE=1), each
// sweeping a bench-side response function and checked against a table model.
module tb_labka13_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start [2];
  logic        abort [2];
  logic        f_in  [2];
  logic [3:0]  x     [2];
  logic        busy  [2];
  logic        done  [2];
  logic [15:0] tt    [2];
  logic [4:0]  ones  [2];

  int          mode [2];
  logic [15:0] lut  [2];

  int errors = 0;
  int checks = 0;

  // Response function: 0 = (x==5), 1 = parity, 2 = constant 1, else lookup
  function automatic logic fmodel(input int m, input logic [3:0] v, input logic [15:0] l);
    case (m)
      0:       return (v == 4'd5);
      1:       return ^v;
      2:       return 1'b1;
      default: return l[v];
    endcase
  endfunction

  assign f_in[0] = fmodel(mode[0], x[0], lut[0]);
  assign f_in[1] = fmodel(mode[1], x[1], lut[1]);

  labka13_sweep_ctrl #(.SETTLE(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .abort_i(abort[0]), .f_in_i(f_in[0]),
    .x_out_o(x[0]), .busy_o(busy[0]), .done_o(done[0]), .tt_o(tt[0]), .ones_cnt_o(ones[0])
  );

  labka13_sweep_ctrl #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .abort_i(abort[1]), .f_in_i(f_in[1]),
    .x_out_o(x[1]), .busy_o(busy[1]), .done_o(done[1]), .tt_o(tt[1]), .ones_cnt_o(ones[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, "_x"},    32'(x[k]),    32'd0);
    chk({tag, "_busy"}, 32'(busy[k]), 32'd0);
    chk({tag, "_done"}, 32'(done[k]), 32'd0);
    chk({tag, "_tt"},   32'(tt[k]),   32'd0);
    chk({tag, "_ones"}, 32'(ones[k]), 32'd0);
  endtask

  // One sweep on instance k, entered #1 after an edge with the DUT in IDLE.
  // abort_at / rst_at give the cycle index (0 = cycle after the accepting edge).
  task automatic sweep(input int k, input int abort_at, input int rst_at,
                       input bit hold, input bit with_abort);
    int s, len, c, e_ones;
    logic [15:0] e_tt, mask;
    s = (k == 0) ? 2 : 1;
    len = 16 * (s + 1);
    e_tt = '0;
    e_ones = 0;
    for (int i = 0; i < 16; i++) begin
      e_tt[i] = fmodel(mode[k], 4'(i), lut[k]);
      e_ones += int'(e_tt[i]);
    end

    start[k] = 1'b1;
    if (with_abort) abort[k] = 1'b1;
    cyc();
    abort[k] = 1'b0;
    if (!hold) start[k] = 1'b0;
    chk("accept_tt", 32'(tt[k]), 32'd0);
    chk("accept_ones", 32'(ones[k]), 32'd0);

    for (int n = 0; n < len; n++) begin
      chk("x_step", 32'(x[k]), 32'(n / (s + 1)));
      chk("busy_run", 32'(busy[k]), 32'd1);
      chk("done_run", 32'(done[k]), 32'd0);
      if (n == abort_at) begin
        abort[k] = 1'b1;
        cyc();
        abort[k] = 1'b0;
        c = n / (s + 1);
        mask = 16'((32'd1 << c) - 32'd1);
        chk("abort_busy", 32'(busy[k]), 32'd0);
        chk("abort_done", 32'(done[k]), 32'd0);
        chk("abort_tt", 32'(tt[k]), 32'(e_tt & mask));
        chk("abort_ones", 32'(ones[k]), 32'($countones(e_tt & mask)));
        for (int j = 0; j < s + 2; j++) begin
          cyc();
          chk("abort_nodone", 32'(done[k]), 32'd0);
          chk("abort_idle", 32'(busy[k]), 32'd0);
        end
        return;
      end
      if (n == rst_at) begin
        rst_n = 1'b0;
        #2;
        chk_zero(k, "rst_async");
        cyc();
        rst_n = 1'b1;
        chk_zero(k, "rst_after");
        return;
      end
      cyc();
    end

    chk("done_pulse", 32'(done[k]), 32'd1);
    chk("done_busy", 32'(busy[k]), 32'd0);
    chk("done_x", 32'(x[k]), 32'd15);
    chk("done_tt", 32'(tt[k]), 32'(e_tt));
    chk("done_ones", 32'(ones[k]), 32'(e_ones));
    cyc();
    chk("post_done", 32'(done[k]), 32'd0);
    chk("post_busy", 32'(busy[k]), 32'd0);
    chk("post_x", 32'(x[k]), 32'd15);
    chk("post_tt", 32'(tt[k]), 32'(e_tt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, ab;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0;
      abort[k] = 1'b0;
      mode[k]  = 0;
      lut[k]   = '0;
    end
    #3;
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    #9;
    rst_n = 1'b1;
    cyc();
    chk_zero(0, "idle0");

    // x==5 detector, then parity
    mode[0] = 0;
    sweep(0, -1, -1, 1'b0, 1'b0);
    chk("eq5_tt_const", 32'(tt[0]), 32'h0020);
    mode[0] = 1;
    sweep(0, -1, -1, 1'b0, 1'b0);

    // abort in IDLE is ignored and results are held
    abort[0] = 1'b1;
    cyc();
    cyc();
    abort[0] = 1'b0;
    chk("idle_abort_busy", 32'(busy[0]), 32'd0);
    chk("idle_abort_tt", 32'(tt[0]), 32'h6996);
    chk("idle_abort_ones", 32'(ones[0]), 32'd8);

    // abort in SETTLE of idx 4, then in SAMPLE of idx 7
    sweep(0, 4 * 3, -1, 1'b0, 1'b0);
    chk("abort4_tt_const", 32'(tt[0]), 32'h0006);
    sweep(0, 7 * 3 + 2, -1, 1'b0, 1'b0);

    // start and abort together in IDLE: start wins
    sweep(0, -1, -1, 1'b0, 1'b1);

    // start held high across back-to-back sweeps
    sweep(0, -1, -1, 1'b1, 1'b0);
    sweep(0, -1, -1, 1'b1, 1'b0);
    sweep(0, -1, -1, 1'b0, 1'b0);

    // reset at idx 9, then a clean sweep
    sweep(0, -1, 9 * 3, 1'b0, 1'b0);
    sweep(0, -1, -1, 1'b0, 1'b0);

    // SETTLE=1 instance: constant 1 (no wrap), then parity
    mode[1] = 2;
    sweep(1, -1, -1, 1'b0, 1'b0);
    chk("const_ones_const", 32'(ones[1]), 32'd16);
    mode[1] = 1;
    sweep(1, -1, -1, 1'b0, 1'b0);

    // random lookup tables with occasional random aborts
    for (int r = 0; r < 12; r++) begin
      int k;
      k = int'($urandom_range(1, 0));
      s = (k == 0) ? 2 : 1;
      mode[k] = 3;
      lut[k] = 16'($urandom);
      ab = ($urandom_range(2, 0) == 0) ? int'($urandom_range(16 * (s + 1) - 1, 0)) : -1;
      sweep(k, ab, -1, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
